prism_cfg_readback: RTL and testbench
=====================================

// Module: prism_cfg_readback
// PURPOSE
//  Read-side counterpart of the config latch chain. Streams the flattened chain contents
//  (DEPTH entries x WIDTH bits) out as BUS_W-bit beats on a valid/ready port, so the
//  host can verify loaded config. Sits between the chain's flat output and the host
//  register interface.
// PARAMETERS
//  WIDTH   48  bits per chain entry
//  DEPTH   8   number of chain entries
//  BUS_W   32  readback beat width; CHUNKS = ceil(WIDTH/BUS_W) beats per entry
// PORTS
//  clk       in   1              single clock, all logic rising-edge
//  rst       in   1              synchronous, active-high reset
//  start     in   1              one-cycle request to begin a readback
//  abort     in   1              cancel an in-progress readback
//  cfg_in    in   WIDTH*DEPTH    flat chain contents, entry j at [(j+1)*WIDTH-1 : j*WIDTH]
//  rd_valid  out  1              beat available
//  rd_ready  in   1              host accepts beat when rd_valid && rd_ready
//  rd_data   out  BUS_W          beat payload
//  rd_last   out  1              marks final beat (entry DEPTH-1, chunk CHUNKS-1)
//  busy      out  1              readback in progress
//  done      out  1              one-cycle pulse after final beat accepted
// BEHAVIOUR
//  - Reset: state=IDLE; rd_valid=0, rd_data=0, rd_last=0, busy=0, done=0; counters=0.
//  - FSM: IDLE -> SEND on start; SEND -> DONE when last beat handshakes; DONE -> IDLE
//    after 1 cycle (done=1 in DONE only). abort in SEND -> IDLE, no done pulse.
//  - Beat order: entry 0 first; within an entry, chunk 0 = bits [BUS_W-1:0] first.
//    A final partial chunk is zero-padded in its upper bits.
//  - Counters: ent_idx 0..DEPTH-1, chk_idx 0..CHUNKS-1. Both advance only on a
//    handshake; chk_idx wraps to 0 and increments ent_idx; no wrap past the last beat.
//  - Latency: start in cycle N -> rd_valid=1 with beat 0 in cycle N+1. With rd_ready
//    held high, one beat per cycle; total DEPTH*CHUNKS beats (16 by default).
//  - rd_data/rd_last are registered; held stable while rd_valid && !rd_ready.
//  - cfg_in is sampled per beat when the beat register loads; host keeps chain static.
//  - start while busy or in DONE: ignored. start and abort same cycle in IDLE: start wins.
//  - abort same cycle as the last handshake: abort wins (IDLE, no done).
//  - rst mid-readback: all outputs to reset values on the next edge; next start restarts
//    at entry 0 chunk 0.
//  - busy=1 in SEND and DONE.
// STRUCTURE
//  - Shared package prism_cfg_pkg: state enum {IDLE,SEND,DONE}; function
//    cfg_chunks(WIDTH,BUS_W); counter width via $clog2 of DEPTH and CHUNKS.
//  - Sub-module prism_cfg_chunk_sel: combinational
//    (cfg_in, ent_idx, chk_idx) -> zero-padded BUS_W slice.
//  - Top holds the FSM, counters and the output register.
// TESTING
//  1. Entry j = {WIDTH{j}} pattern, start, rd_ready=1 -> 16 beats in cycles N+1..N+16,
//     order e0c0,e0c1,...,e7c1; c1 upper 16 bits = 0; rd_last only on beat 16;
//     done pulses cycle N+17.
//  2. rd_ready toggles 1-0-1 -> rd_data/rd_last stable on stall cycles; the same 16 beats
//     arrive with no loss or duplication.
//  3. abort after 5 handshakes -> rd_valid=0 and busy=0 next cycle, no done pulse;
//     a new start resumes from beat e0c0.
//  4. start pulsed again during SEND -> no restart; beat sequence unchanged.
//  5. rst asserted at beat 9 -> all outputs 0 next cycle; a later start streams the full
//     16 beats.
//  6. Parameters WIDTH=32, BUS_W=32, DEPTH=4 -> 4 beats, no padding;
//     rd_last on entry 3.

Source files
------------

// File: rtl/prism_cfg_pkg.sv
// Shared types and sizing helpers for the config readback path.
package prism_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } cfg_state_e;

    // Number of bus beats needed to carry one chain entry.
    function automatic int cfg_chunks(input int width, input int bus_w);
        return (width + bus_w - 1) / bus_w;
    endfunction

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/prism_cfg_chunk_sel.sv
// Selects one BUS_W-bit chunk of one chain entry; a final partial chunk is
// zero-padded in its upper bits.
module prism_cfg_chunk_sel
    import prism_cfg_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8,
    parameter int BUS_W = 32
) (
    input  logic [WIDTH*DEPTH-1:0]                 cfg_in,
    input  logic [cnt_width(DEPTH)-1:0]            ent_idx,
    input  logic [cnt_width(cfg_chunks(WIDTH, BUS_W))-1:0] chk_idx,
    output logic [BUS_W-1:0]                       chunk
);

    localparam int CHUNKS = cfg_chunks(WIDTH, BUS_W);

    logic [WIDTH-1:0]        entry_s;
    logic [CHUNKS*BUS_W-1:0] padded_s;

    // Pick the entry, zero-extend it to whole beats, then pick the chunk.
    always_comb begin
        entry_s  = cfg_in[int'(ent_idx)*WIDTH +: WIDTH];
        padded_s = '0;
        padded_s[WIDTH-1:0] = entry_s;
        chunk    = padded_s[int'(chk_idx)*BUS_W +: BUS_W];
    end

endmodule

// File: rtl/prism_cfg_readback.sv
// Streams the flattened config chain out as BUS_W-bit beats on a
// valid/ready port, entry 0 chunk 0 first, with a done pulse at the end.
module prism_cfg_readback
    import prism_cfg_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8,
    parameter int BUS_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WIDTH*DEPTH-1:0] cfg_in,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [BUS_W-1:0]       rd_data,
    output logic                   rd_last,
    output logic                   busy,
    output logic                   done
);

    localparam int CHUNKS = cfg_chunks(WIDTH, BUS_W);
    localparam int ENT_W  = cnt_width(DEPTH);
    localparam int CHK_W  = cnt_width(CHUNKS);
    localparam logic [ENT_W-1:0] LAST_ENT = ENT_W'(DEPTH - 1);
    localparam logic [CHK_W-1:0] LAST_CHK = CHK_W'(CHUNKS - 1);

    cfg_state_e       state_r, state_s;
    logic [ENT_W-1:0] ent_idx_r, ent_idx_s;
    logic [CHK_W-1:0] chk_idx_r, chk_idx_s;
    logic             rd_valid_r, rd_valid_s;
    logic [BUS_W-1:0] rd_data_r, rd_data_s;
    logic             rd_last_r, rd_last_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             load_s;
    logic             clr_s;
    logic             hs_s;
    logic [BUS_W-1:0] sel_data_s;

    assign hs_s = rd_valid_r & rd_ready;

    // The beat register always loads the chunk addressed by the next indices.
    prism_cfg_chunk_sel #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BUS_W (BUS_W)
    ) u_chunk_sel (
        .cfg_in  (cfg_in),
        .ent_idx (ent_idx_s),
        .chk_idx (chk_idx_s),
        .chunk   (sel_data_s)
    );

    // Next-state, counter advance and beat-register control.
    always_comb begin
        state_s    = state_r;
        ent_idx_s  = ent_idx_r;
        chk_idx_s  = chk_idx_r;
        rd_valid_s = rd_valid_r;
        done_s     = 1'b0;
        load_s     = 1'b0;
        clr_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s    = SEND;
                    ent_idx_s  = '0;
                    chk_idx_s  = '0;
                    rd_valid_s = 1'b1;
                    load_s     = 1'b1;
                end else begin
                    state_s    = IDLE;
                end
            end
            SEND: begin
                if (abort) begin
                    // Abort beats a coincident final handshake: no done pulse.
                    state_s    = IDLE;
                    ent_idx_s  = '0;
                    chk_idx_s  = '0;
                    rd_valid_s = 1'b0;
                    clr_s      = 1'b1;
                end else if (hs_s) begin
                    if (rd_last_r) begin
                        state_s    = DONE;
                        ent_idx_s  = '0;
                        chk_idx_s  = '0;
                        rd_valid_s = 1'b0;
                        clr_s      = 1'b1;
                        done_s     = 1'b1;
                    end else begin
                        load_s = 1'b1;
                        if (chk_idx_r == LAST_CHK) begin
                            chk_idx_s = '0;
                            ent_idx_s = ent_idx_r + 1'b1;
                        end else begin
                            chk_idx_s = chk_idx_r + 1'b1;
                        end
                    end
                end else begin
                    state_s = SEND;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                ent_idx_s  = '0;
                chk_idx_s  = '0;
                rd_valid_s = 1'b0;
                clr_s      = 1'b1;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // Beat payload and last flag: load a new chunk, clear, or hold on stall.
    always_comb begin
        if (load_s) begin
            rd_data_s = sel_data_s;
            rd_last_s = (ent_idx_s == LAST_ENT) && (chk_idx_s == LAST_CHK);
        end else if (clr_s) begin
            rd_data_s = '0;
            rd_last_s = 1'b0;
        end else begin
            rd_data_s = rd_data_r;
            rd_last_s = rd_last_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_idx_r  <= '0;
            chk_idx_r  <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
            rd_last_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            ent_idx_r  <= ent_idx_s;
            chk_idx_r  <= chk_idx_s;
            rd_valid_r <= rd_valid_s;
            rd_data_r  <= rd_data_s;
            rd_last_r  <= rd_last_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign rd_last  = rd_last_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_prism_cfg_readback.sv
// Directed bench for prism_cfg_readback: default 48x8/32 instance plus a
// 32x4/32 instance with no padding.
module tb_prism_cfg_readback;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    // Default-parameter instance.
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [383:0] cfg_in;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic [31:0]  rd_data;
    logic         rd_last;
    logic         busy;
    logic         done;

    // Small instance: WIDTH=32, DEPTH=4, BUS_W=32.
    logic         start_b = 1'b0;
    logic         abort_b = 1'b0;
    logic [127:0] cfg_b;
    logic         valid_b;
    logic         ready_b = 1'b0;
    logic [31:0]  data_b;
    logic         last_b;
    logic         busy_b;
    logic         done_b;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    prism_cfg_readback u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cfg_in   (cfg_in),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .busy     (busy),
        .done     (done)
    );

    prism_cfg_readback #(
        .WIDTH (32),
        .DEPTH (4),
        .BUS_W (32)
    ) u_small (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .abort    (abort_b),
        .cfg_in   (cfg_b),
        .rd_valid (valid_b),
        .rd_ready (ready_b),
        .rd_data  (data_b),
        .rd_last  (last_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    // Entry j is byte (A0+j) repeated six times; chunk 1 carries only two bytes.
    function automatic logic [31:0] exp_beat(input int k);
        logic [7:0] b;
        b = 8'hA0 + 8'(k / 2);
        if ((k % 2) == 0) begin
            return {b, b, b, b};
        end else begin
            return {16'h0000, b, b};
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Consume nbeats beats; ready_mode 1 toggles ready 1-0-1, poke re-pulses start.
    task automatic stream(input int ready_mode, input int nbeats, input bit poke);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < nbeats && cyc < 200) begin
            check($sformatf("valid_b%0d", k), 32'(rd_valid), 32'd1);
            check($sformatf("data_b%0d", k), rd_data, exp_beat(k));
            check($sformatf("last_b%0d", k), 32'(rd_last), 32'(k == 15));
            check($sformatf("busy_b%0d", k), 32'(busy), 32'd1);
            rd_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            start    = poke && (cyc == 3);
            tick();
            start = 1'b0;
            if (rd_ready) begin
                k++;
            end
            cyc++;
        end
        rd_ready = 1'b0;
        if (cyc >= 200) begin
            check("stream_timeout", 32'(cyc), 32'd0);
        end
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_done_off"}, 32'(done), 32'd0);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int j = 0; j < 8; j++) begin
            logic [7:0] b;
            b = 8'hA0 + 8'(j);
            cfg_in[j*48 +: 48] = {6{b}};
        end
        for (int j = 0; j < 4; j++) begin
            cfg_b[j*32 +: 32] = 32'hC0DE_0000 + 32'(j);
        end

        // Reset state.
        tick();
        tick();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_last", 32'(rd_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // 1: full stream, ready high.
        pulse_start();
        stream(0, 16, 1'b0);
        check_done("t1");

        // 2: ready toggling.
        pulse_start();
        stream(1, 16, 1'b0);
        check_done("t2");

        // 3: abort after five handshakes, then restart from e0c0.
        pulse_start();
        stream(0, 5, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_valid", 32'(rd_valid), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_done", 32'(done), 32'd0);
        tick();
        check("t3_done_later", 32'(done), 32'd0);
        pulse_start();
        stream(0, 16, 1'b0);
        check_done("t3r");

        // 4: start re-pulsed during SEND is ignored.
        pulse_start();
        stream(0, 16, 1'b1);
        check_done("t4");

        // 5: reset at beat 9, then a full stream.
        pulse_start();
        stream(0, 9, 1'b0);
        check("t5_pre_data", rd_data, exp_beat(9));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", 32'(rd_valid), 32'd0);
        check("t5_data", rd_data, 32'd0);
        check("t5_last", 32'(rd_last), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        pulse_start();
        stream(0, 16, 1'b0);
        check_done("t5r");

        // Abort coincident with the final handshake wins.
        pulse_start();
        stream(0, 15, 1'b0);
        check("ab_last", 32'(rd_last), 32'd1);
        abort    = 1'b1;
        rd_ready = 1'b1;
        tick();
        abort    = 1'b0;
        rd_ready = 1'b0;
        check("ab_done", 32'(done), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_valid", 32'(rd_valid), 32'd0);

        // start and abort together in IDLE: start wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_valid", 32'(rd_valid), 32'd1);
        check("sa_data", rd_data, exp_beat(0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("sa_cleanup", 32'(busy), 32'd0);

        // 6: WIDTH=32, BUS_W=32, DEPTH=4 instance.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        ready_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("s_valid%0d", k), 32'(valid_b), 32'd1);
            check($sformatf("s_data%0d", k), data_b, 32'hC0DE_0000 + 32'(k));
            check($sformatf("s_last%0d", k), 32'(last_b), 32'(k == 3));
            tick();
        end
        ready_b = 1'b0;
        check("s_done", 32'(done_b), 32'd1);
        check("s_valid_end", 32'(valid_b), 32'd0);
        tick();
        check("s_done_off", 32'(done_b), 32'd0);
        check("s_busy_off", 32'(busy_b), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
